instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Fetch-side producer of the 32-bit Instruction word consumed by the instruction register.
//  The control FSM pulses fetch_start with the current PC. The unit runs a req/ack transaction
//  to instruction memory, captures the returned word and flags it valid for exactly one cycle.
//  It also enforces word alignment, a bounded wait for ack, and flush on branch/exception.
// PARAMETERS
//  TIMEOUT   15    max cycles mem_req may stay high without mem_ack before abort (1..255)
//  CNT_W     8     width of the wait counter; must hold TIMEOUT
// PORTS
//  clk          in   1   system clock, all state changes on rising edge
//  reset        in   1   synchronous, active-high reset
//  fetch_start  in   1   request a fetch at fetch_pc; honoured only when busy==0
//  fetch_pc     in   32  byte address of the instruction to fetch
//  flush        in   1   abort any in-flight fetch; no instruction is delivered
//  mem_req      out  1   memory request; held high until ack/timeout/flush
//  mem_addr     out  32  word-aligned address; stable while mem_req==1
//  mem_ack      in   1   memory response strobe; valid only while mem_req==1
//  mem_rdata    in   32  instruction word, sampled on the cycle mem_ack==1
//  instruction  out  32  last successfully fetched word (feeds the IR Instruction input)
//  instr_valid  out  1   one-cycle pulse: instruction was updated this cycle
//  busy         out  1   1 in any state other than IDLE
//  fetch_error  out  1   one-cycle pulse: misaligned PC or timeout
// BEHAVIOUR
//  Reset (sync, high): state=IDLE; mem_req=0, mem_addr=0, instruction=0, instr_valid=0,
//   busy=0, fetch_error=0, wait counter=0. Reset wins over every other input in the same cycle.
//  Reset mid-transaction drops mem_req on the next edge. A late mem_ack afterwards is ignored.
//  States: IDLE, WAIT (registered outputs only, no comb paths from inputs to outputs).
//  IDLE:
//   - fetch_start=1 with fetch_pc[1:0]!=0 -> stay IDLE and pulse fetch_error next cycle.
//     mem_req stays 0.
//   - fetch_start=1 with an aligned PC -> WAIT next edge. mem_req=1, mem_addr=fetch_pc,
//     counter=0.
//   - flush in IDLE has no effect. fetch_start and flush in the same cycle -> flush wins;
//     no request is issued.
//  WAIT:
//   - mem_ack=1 -> instruction<=mem_rdata, instr_valid=1 for one cycle; mem_req=0; IDLE.
//   - flush=1 -> mem_req=0, IDLE, no instr_valid, instruction unchanged.
//     flush beats a same-cycle mem_ack.
//   - no ack and counter==TIMEOUT-1 -> mem_req=0, fetch_error pulse, IDLE, instruction unchanged.
//   - otherwise counter+1, outputs held.
//   - fetch_start is ignored; the bench must see no second request.
//  Latency: fetch_start sampled at edge N -> mem_req high after N. If ack is sampled at
//   edge M -> instr_valid and the new instruction are visible after M. With a zero-wait
//   memory (ack in the first req cycle) instr_valid is high 2 cycles after fetch_start.
//  Back-to-back: a new fetch_start is accepted in the same cycle instr_valid is high
//   (state already IDLE).
//  instruction holds its value indefinitely between fetches (IR-load semantics).
//  instr_valid and fetch_error are never high together.
//  mem_addr[1:0] is always 0 while mem_req=1.
// TESTING
//  1 Zero-wait: reset; fetch_pc=0x0000_0040, start; ack next cycle with rdata=0x8C22_0004 ->
//    instr_valid 1 cycle, instruction=0x8C22_0004, mem_req low after.
//  2 Wait states: ack after 5 cycles, rdata=0x0043_0820 -> mem_addr stable at PC for all 5,
//    instr_valid once, busy low the same cycle.
//  3 Timeout: TIMEOUT=15, no ack -> mem_req high exactly 15 cycles, then fetch_error pulse;
//    instruction keeps prior value.
//  4 Misaligned: fetch_pc=0x0000_0042 -> fetch_error next cycle, mem_req never asserts, busy stays 0.
//  5 Flush vs ack: flush and mem_ack in the same WAIT cycle -> no instr_valid, instruction unchanged;
//    a start in the next cycle fetches normally.
//  6 Reset mid-WAIT, then a late ack -> outputs at reset values; ack ignored; start while busy
//    produces no extra request.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus: control-FSM request/flush, instruction-memory handshake and IR-facing results.
interface instruction_fetch_unit_if;
  logic        fetch_start;
  logic [31:0] fetch_pc;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        busy;
  logic        fetch_error;

  // The fetch unit drives the memory request and the results.
  modport master (
    input  fetch_start, fetch_pc, flush, mem_ack, mem_rdata,
    output mem_req, mem_addr, instruction, instr_valid, busy, fetch_error
  );

  modport slave (
    output fetch_start, fetch_pc, flush, mem_ack, mem_rdata,
    input  mem_req, mem_addr, instruction, instr_valid, busy, fetch_error
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Runs one req/ack transaction per accepted fetch_start and delivers the word with a one-cycle valid.
// state | meaning
// IDLE  | no request outstanding; accepts fetch_start
// WAIT  | mem_req high at mem_addr; waiting for ack, flush or timeout
module instruction_fetch_unit #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input logic clk,
  input logic reset,
  instruction_fetch_unit_if.master bus
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      instr_q, instr_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // flush suppresses a same-cycle start so no request leaks out
        if (!bus.flush && bus.fetch_start) begin
          if (bus.fetch_pc[1:0] != 2'b00) begin
            err_d = 1'b1;
          end else begin
            state_d = WAIT;
            req_d   = 1'b1;
            addr_d  = bus.fetch_pc;
            cnt_d   = '0;
          end
        end
      end
      WAIT: begin
        if (bus.flush) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end else if (bus.mem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          instr_d = bus.mem_rdata;
          valid_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          req_d   = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_req     = req_q;
  assign bus.mem_addr    = addr_q;
  assign bus.instruction = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.fetch_error = err_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench: expected words queued when ack is driven, popped when instr_valid appears.
module tb_instruction_fetch_unit;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  int req_rises = 0;
  int valid_seen = 0;
  int exp_reqs = 0;
  int exp_valids = 0;
  logic prev_req = 1'b0;
  logic [31:0] exp_q[$];

  instruction_fetch_unit_if bus();

  instruction_fetch_unit #(.TIMEOUT(15), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.mem_req && !prev_req) req_rises++;
    prev_req = bus.mem_req;
    if (bus.instr_valid) begin
      valid_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", bus.instruction, 32'hxxxx_xxxx);
      end else begin
        check("sb_instruction", bus.instruction, exp_q.pop_front());
      end
      check("valid_err_exclusive", {31'b0, bus.fetch_error}, 32'd0);
    end
    if (bus.mem_req) check("addr_aligned", {30'b0, bus.mem_addr[1:0]}, 32'd0);
  end

  task automatic check_reset_vals();
    check("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_instruction", bus.instruction, 32'd0);
    check("rst_instr_valid", {31'b0, bus.instr_valid}, 32'd0);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_fetch_error", {31'b0, bus.fetch_error}, 32'd0);
  endtask

  task automatic start(input logic [31:0] pc);
    bus.fetch_start = 1'b1;
    bus.fetch_pc    = pc;
    tick();
    bus.fetch_start = 1'b0;
  endtask

  task automatic ack(input logic [31:0] data);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = data;
    exp_q.push_back(data);
    exp_valids++;
    tick();
    bus.mem_ack = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    bus.fetch_start = 1'b0;
    bus.fetch_pc    = '0;
    bus.flush       = 1'b0;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = '0;
    tick();
    tick();
    check_reset_vals();
    reset = 1'b0;
    tick();

    // 1: zero-wait fetch
    start(32'h0000_0040); exp_reqs++;
    check("t1_req", {31'b0, bus.mem_req}, 32'd1);
    check("t1_addr", bus.mem_addr, 32'h0000_0040);
    check("t1_busy", {31'b0, bus.busy}, 32'd1);
    ack(32'h8C22_0004);
    check("t1_valid", {31'b0, bus.instr_valid}, 32'd1);
    check("t1_instr", bus.instruction, 32'h8C22_0004);
    check("t1_req_low", {31'b0, bus.mem_req}, 32'd0);
    tick();
    check("t1_valid_pulse", {31'b0, bus.instr_valid}, 32'd0);
    check("t1_instr_hold", bus.instruction, 32'h8C22_0004);

    // 2: five wait states
    start(32'h0000_0100); exp_reqs++;
    for (int i = 0; i < 5; i++) begin
      check("t2_req", {31'b0, bus.mem_req}, 32'd1);
      check("t2_addr", bus.mem_addr, 32'h0000_0100);
      tick();
    end
    ack(32'h0043_0820);
    check("t2_valid", {31'b0, bus.instr_valid}, 32'd1);
    check("t2_busy", {31'b0, bus.busy}, 32'd0);
    check("t2_instr", bus.instruction, 32'h0043_0820);
    tick();
    check("t2_valid_pulse", {31'b0, bus.instr_valid}, 32'd0);

    // 3: timeout
    start(32'h0000_0200); exp_reqs++;
    n = 0;
    while (bus.mem_req && n < 40) begin
      n++;
      tick();
    end
    check("t3_req_cycles", n, 32'd15);
    check("t3_error", {31'b0, bus.fetch_error}, 32'd1);
    check("t3_no_valid", {31'b0, bus.instr_valid}, 32'd0);
    check("t3_instr_kept", bus.instruction, 32'h0043_0820);
    tick();
    check("t3_error_pulse", {31'b0, bus.fetch_error}, 32'd0);

    // 4: misaligned
    start(32'h0000_0042);
    check("t4_error", {31'b0, bus.fetch_error}, 32'd1);
    check("t4_req", {31'b0, bus.mem_req}, 32'd0);
    check("t4_busy", {31'b0, bus.busy}, 32'd0);
    tick();
    check("t4_error_pulse", {31'b0, bus.fetch_error}, 32'd0);
    check("t4_req_after", {31'b0, bus.mem_req}, 32'd0);

    // flush beats start in IDLE
    bus.flush = 1'b1;
    start(32'h0000_0400);
    bus.flush = 1'b0;
    check("flush_idle_req", {31'b0, bus.mem_req}, 32'd0);
    check("flush_idle_busy", {31'b0, bus.busy}, 32'd0);

    // 5: flush and ack together
    start(32'h0000_0300); exp_reqs++;
    tick();
    bus.flush     = 1'b1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.flush   = 1'b0;
    bus.mem_ack = 1'b0;
    check("t5_no_valid", {31'b0, bus.instr_valid}, 32'd0);
    check("t5_req", {31'b0, bus.mem_req}, 32'd0);
    check("t5_busy", {31'b0, bus.busy}, 32'd0);
    check("t5_instr_kept", bus.instruction, 32'h0043_0820);
    start(32'h0000_0304); exp_reqs++;
    check("t5_refetch_addr", bus.mem_addr, 32'h0000_0304);
    ack(32'h1234_5678);
    check("t5_valid", {31'b0, bus.instr_valid}, 32'd1);
    check("t5_instr", bus.instruction, 32'h1234_5678);

    // back-to-back: start in the instr_valid cycle
    start(32'h0000_0308); exp_reqs++;
    check("b2b_req", {31'b0, bus.mem_req}, 32'd1);
    check("b2b_addr", bus.mem_addr, 32'h0000_0308);
    ack(32'hCAFE_0001);
    check("b2b_instr", bus.instruction, 32'hCAFE_0001);

    // 6: start while busy, reset mid-WAIT, late ack
    start(32'h0000_0500); exp_reqs++;
    start(32'h0000_0600);
    check("t6_addr_stable", bus.mem_addr, 32'h0000_0500);
    check("t6_still_req", {31'b0, bus.mem_req}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_vals();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hBADB_AD00;
    tick();
    bus.mem_ack = 1'b0;
    check("t6_late_valid", {31'b0, bus.instr_valid}, 32'd0);
    check("t6_late_instr", bus.instruction, 32'd0);
    check("t6_late_req", {31'b0, bus.mem_req}, 32'd0);
    tick();
    tick();

    check("req_count", req_rises, exp_reqs);
    check("valid_count", valid_seen, exp_valids);
    check("sb_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
